// File: rtl/sig_monitor_pkg.sv
// Shared definitions for the MMIO signature monitor.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents: window offsets relative to BASE_ADDR, run-control state and
// done-cause encodings, and a helper that sizes the record channel field.
package sig_monitor_pkg;

    // Offsets inside the signature window, relative to BASE_ADDR.
    localparam logic [31:0] OFS_STOP    = 32'h0000_0000;
    localparam logic [31:0] OFS_TRAP    = 32'h0000_0008;
    localparam logic [31:0] OFS_DUMP0   = 32'h0000_0010;
    localparam logic [31:0] DUMP_STRIDE = 32'h0000_0008;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } run_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_STOP,
        CAUSE_TRAP,
        CAUSE_SIMLEN
    } done_cause_e;

    // The channel field is at least one bit wide, even with a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sig_rec_fifo.sv
// Generic synchronous FIFO holding captured signature records.
// Latency: a push is visible on pop_dat_o / empty_o one cycle later.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   push_i, push_dat_i      write side
//   pop_i                   consume the head entry (ignored when empty)
//   pop_dat_o               head entry, forced to zero while empty
//   empty_o, count_o        status: empty flag and current occupancy
module sig_rec_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, empty, do_push, do_pop;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_W'(DEPTH));
        do_pop  = pop_i & ~empty;
        // A pop in the same cycle frees the slot the push needs.
        do_push = push_i & (~full | do_pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign pop_dat_o = empty ? '0 : mem_q[rd_ptr_q];
    assign empty_o   = empty;
    assign count_o   = cnt_q;

endmodule

// File: rtl/mmio_sig_monitor.sv
// Snoops MMIO writes, decodes the signature window (stop, trap, dump channels) and runs end-of-test control.
// Latency: dump write to rec_valid_o 1 cycle; stop/trap to stop_req_o 1 cycle, to done_o STOP_DRAIN+1 cycles.
// Backpressure: rec_ready_i low holds the head record; a dump arriving with the FIFO full is dropped and flagged.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   mmio_*                           snooped MMIO request (address, data, data taint)
//   trap_stop_en_i                   a trap also starts the stop drain
//   simlen_i                         cycle limit in RUN, 0 = unlimited
//   rec_*                            captured record stream, valid/ready
//   stop_req_o, trap_seen_o, done_o, done_cause_o, overflow_o, step_cnt_o   run status
module mmio_sig_monitor
    import sig_monitor_pkg::*;
#(
    parameter  int                ADDR_W        = 32,
    parameter  int                DATA_W        = 64,
    parameter  logic [ADDR_W-1:0] BASE_ADDR     = 32'h6000_0000,
    parameter  int                NUM_CH        = 3,
    parameter  int                FIFO_DEPTH    = 16,
    parameter  int                IDX_W         = 16,
    parameter  int                STOP_DRAIN    = 50,
    parameter  int                CH0_IDX_START = 1,
    localparam int                CH_W          = ch_width(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mmio_req_i,
    input  logic              mmio_we_i,
    input  logic [ADDR_W-1:0] mmio_addr_i,
    input  logic [DATA_W-1:0] mmio_wdata_i,
    input  logic [DATA_W-1:0] mmio_wdata_t0_i,
    input  logic              trap_stop_en_i,
    input  logic [31:0]       simlen_i,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [CH_W-1:0]   rec_ch_o,
    output logic [IDX_W-1:0]  rec_idx_o,
    output logic [DATA_W-1:0] rec_data_o,
    output logic [DATA_W-1:0] rec_taint_o,
    output logic              stop_req_o,
    output logic              trap_seen_o,
    output logic              done_o,
    output logic [1:0]        done_cause_o,
    output logic              overflow_o,
    output logic [31:0]       step_cnt_o
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] taint;
    } rec_t;

    localparam int REC_W = $bits(rec_t);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Address decode (combinational on the current request)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] ofs, dump_ofs, dump_num;
    logic              hit_stop, hit_trap, hit_dump;
    logic [CH_W-1:0]   dump_ch;

    always_comb begin
        // Addresses below the base wrap to huge offsets and miss every slot.
        ofs      = mmio_addr_i - BASE_ADDR;
        dump_ofs = ofs - ADDR_W'(OFS_DUMP0);
        dump_num = dump_ofs >> $clog2(DUMP_STRIDE);

        hit_stop = mmio_req_i & mmio_we_i & (ofs == ADDR_W'(OFS_STOP));
        // Any access to the trap slot counts, reads included.
        hit_trap = mmio_req_i & (ofs == ADDR_W'(OFS_TRAP));
        hit_dump = mmio_req_i & mmio_we_i
                 & (ofs >= ADDR_W'(OFS_DUMP0))
                 & ((dump_ofs & ADDR_W'(DUMP_STRIDE - 32'd1)) == '0)
                 & (dump_num < ADDR_W'(NUM_CH));
        dump_ch  = dump_num[CH_W-1:0];
    end

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    run_state_e  state_q, state_d;
    done_cause_e cause_q, cause_d;
    logic [31:0] step_cnt_q, step_cnt_d;
    logic [31:0] drain_cnt_q, drain_cnt_d;
    logic        stop_req_q, stop_req_d;
    logic        done_q, done_d;
    logic        trap_seen_q, trap_seen_d;
    logic        simlen_hit;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        step_cnt_d  = step_cnt_q;
        drain_cnt_d = drain_cnt_q;
        stop_req_d  = stop_req_q;
        done_d      = done_q;
        trap_seen_d = trap_seen_q;
        simlen_hit  = (simlen_i != 32'd0) && (step_cnt_q == simlen_i - 32'd1);

        unique case (state_q)
            RUN: begin
                step_cnt_d = step_cnt_q + 32'd1;
                if (hit_trap) begin
                    trap_seen_d = 1'b1;
                end
                // The cycle limit outranks a stop or trap arriving together with it.
                if (simlen_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cause_d = CAUSE_SIMLEN;
                end else if (hit_stop || (hit_trap && trap_stop_en_i)) begin
                    cause_d     = hit_stop ? CAUSE_STOP : CAUSE_TRAP;
                    stop_req_d  = 1'b1;
                    drain_cnt_d = 32'(STOP_DRAIN);
                    if (STOP_DRAIN == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // drain_cnt counts the DRAIN cycles still to spend including this one,
                // so done_o rises exactly STOP_DRAIN+1 cycles after the stop hit.
                drain_cnt_d = drain_cnt_q - 32'd1;
                if (drain_cnt_q <= 32'd1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // DONE holds everything until reset.
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            cause_q     <= CAUSE_NONE;
            step_cnt_q  <= '0;
            drain_cnt_q <= '0;
            stop_req_q  <= 1'b0;
            done_q      <= 1'b0;
            trap_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            step_cnt_q  <= step_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            stop_req_q  <= stop_req_d;
            done_q      <= done_d;
            trap_seen_q <= trap_seen_d;
        end
    end

    // ------------------------------------------------------------------
    // Dump capture, per-channel indices and overflow
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] idx_q [NUM_CH];
    logic [IDX_W-1:0] idx_d [NUM_CH];
    logic [IDX_W-1:0] idx_sel;
    logic             capture;
    logic             overflow_q, overflow_d;
    logic             fifo_empty, fifo_full, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    rec_t             rec_in, rec_out;

    always_comb begin
        capture  = hit_dump & (state_q == RUN);
        fifo_pop = ~fifo_empty & rec_ready_i;
        fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

        idx_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_d[k] = idx_q[k];
            if (dump_ch == CH_W'(k)) begin
                idx_sel = idx_q[k];
                // The index advances even if the record itself is dropped.
                if (capture) begin
                    idx_d[k] = idx_q[k] + IDX_W'(1);
                end
            end
        end

        rec_in.ch    = dump_ch;
        rec_in.idx   = idx_sel;
        rec_in.data  = mmio_wdata_i;
        rec_in.taint = mmio_wdata_t0_i;

        overflow_d = overflow_q | (capture & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx_q[k] <= (k == 0) ? IDX_W'(CH0_IDX_START) : '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx_q[k] <= idx_d[k];
            end
            overflow_q <= overflow_d;
        end
    end

    sig_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (capture),
        .push_dat_i (rec_in),
        .pop_i      (fifo_pop),
        .pop_dat_o  (rec_out),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // ------------------------------------------------------------------
    // Outputs (all driven from flops)
    // ------------------------------------------------------------------
    assign rec_valid_o  = ~fifo_empty;
    assign rec_ch_o     = rec_out.ch;
    assign rec_idx_o    = rec_out.idx;
    assign rec_data_o   = rec_out.data;
    assign rec_taint_o  = rec_out.taint;
    assign stop_req_o   = stop_req_q;
    assign trap_seen_o  = trap_seen_q;
    assign done_o       = done_q;
    assign done_cause_o = cause_q;
    assign overflow_o   = overflow_q;
    assign step_cnt_o   = step_cnt_q;

endmodule

// File: tb/tb_mmio_sig_monitor.sv
// Self-checking bench for mmio_sig_monitor.
// Latency: n/a. Backpressure: rec_ready_i driven by directed steps and $urandom.
// A queue-based model of the record stream and a timestamp model of run control predict every output each cycle.
module tb_mmio_sig_monitor;

    localparam int          NUM_CH = 3;
    localparam int          DEPTH  = 16;
    localparam int          S      = 50;
    localparam logic [31:0] BASE   = 32'h6000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mmio_req, mmio_we;
    logic [31:0] mmio_addr;
    logic [63:0] wdata, wdata_t0;
    logic        trap_en;
    logic [31:0] simlen;
    logic        rec_ready;
    logic        rec_valid;
    logic [1:0]  rec_ch;
    logic [15:0] rec_idx;
    logic [63:0] rec_data, rec_taint;
    logic        stop_req, trap_seen, done, overflow;
    logic [1:0]  done_cause;
    logic [31:0] step_cnt;

    always #5 clk_i = ~clk_i;

    mmio_sig_monitor dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mmio_req_i      (mmio_req),
        .mmio_we_i       (mmio_we),
        .mmio_addr_i     (mmio_addr),
        .mmio_wdata_i    (wdata),
        .mmio_wdata_t0_i (wdata_t0),
        .trap_stop_en_i  (trap_en),
        .simlen_i        (simlen),
        .rec_valid_o     (rec_valid),
        .rec_ready_i     (rec_ready),
        .rec_ch_o        (rec_ch),
        .rec_idx_o       (rec_idx),
        .rec_data_o      (rec_data),
        .rec_taint_o     (rec_taint),
        .stop_req_o      (stop_req),
        .trap_seen_o     (trap_seen),
        .done_o          (done),
        .done_cause_o    (done_cause),
        .overflow_o      (overflow),
        .step_cnt_o      (step_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          ch;
        int          idx;
        logic [63:0] data;
        logic [63:0] taint;
    } exp_rec_t;

    exp_rec_t    q[$];
    int          m_idx[NUM_CH];
    bit          m_run, m_stop, m_trap, m_ovf;
    int          m_cause, m_done_at, now;
    int unsigned m_step;
    int          total, passed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_idx[0] = 1;
        for (int k = 1; k < NUM_CH; k++) m_idx[k] = 0;
        m_run = 1; m_stop = 0; m_trap = 0; m_ovf = 0;
        m_cause = 0; m_done_at = -1; m_step = 0; now = 0;
    endtask

    task automatic compare_all();
        chk("rec_valid", rec_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("rec_ch", rec_ch, q[0].ch);
            chk("rec_idx", rec_idx, q[0].idx);
            chk("rec_data", rec_data, q[0].data);
            chk("rec_taint", rec_taint, q[0].taint);
        end
        chk("done", done, (m_done_at >= 0) && (now >= m_done_at));
        chk("stop_req", stop_req, m_stop);
        chk("cause", done_cause, m_cause);
        chk("trap_seen", trap_seen, m_trap);
        chk("overflow", overflow, m_ovf);
        chk("step_cnt", step_cnt, m_step);
    endtask

    // One clock cycle: apply the rules to the current inputs, clock, then compare.
    task automatic cyc();
        logic [31:0] off;
        int          dch;
        bit          is_stop, is_trap;
        int unsigned step_old;
        exp_rec_t    r;
        off     = mmio_addr - BASE;
        is_stop = mmio_req && mmio_we && (off == 0);
        is_trap = mmio_req && (off == 8);
        dch = -1;
        if (mmio_req && mmio_we && off >= 16 && off[2:0] == 3'd0 && ((off - 16) >> 3) < NUM_CH)
            dch = int'((off - 16) >> 3);
        if (q.size() != 0 && rec_ready) q.delete(0);
        if (m_run) begin
            step_old = m_step;
            m_step++;
            if (dch >= 0) begin
                if (q.size() < DEPTH) begin
                    r.ch = dch; r.idx = m_idx[dch]; r.data = wdata; r.taint = wdata_t0;
                    q.push_back(r);
                end else begin
                    m_ovf = 1;
                end
                m_idx[dch] = (m_idx[dch] + 1) % 65536;
            end
            if (is_trap) m_trap = 1;
            if (simlen != 0 && step_old == simlen - 1) begin
                m_run = 0; m_cause = 3; m_done_at = now + 1;
            end else if (is_stop || (is_trap && trap_en)) begin
                m_run = 0; m_stop = 1; m_cause = is_stop ? 1 : 2; m_done_at = now + 1 + S;
            end
        end
        @(posedge clk_i);
        #1;
        now++;
        compare_all();
    endtask

    task automatic set_idle();
        mmio_req = 0; mmio_we = 0; mmio_addr = 0; wdata = 0; wdata_t0 = 0;
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [31:0] off, input logic [63:0] d, input logic [63:0] t);
        mmio_req = 1; mmio_we = 1; mmio_addr = BASE + off; wdata = d; wdata_t0 = t;
        cyc();
        set_idle();
    endtask

    task automatic rd(input logic [31:0] off);
        mmio_req = 1; mmio_we = 0; mmio_addr = BASE + off; wdata = 64'hdead; wdata_t0 = 0;
        cyc();
        set_idle();
    endtask

    task automatic rand_dump();
        mmio_req  = 1'($urandom_range(1));
        mmio_we   = 1'b1;
        mmio_addr = BASE + 32'd16 + 32'd8 * $urandom_range(3);
        wdata     = {$urandom, $urandom};
        wdata_t0  = {$urandom, $urandom};
    endtask

    // Random traffic over dump slots, an unused channel slot, a misaligned
    // address and an address outside the window; never stop or trap.
    task automatic rand_phase(input int n, input int ready_pct);
        logic [31:0] offs [6];
        offs[0] = 32'h10; offs[1] = 32'h18; offs[2] = 32'h20;
        offs[3] = 32'h28; offs[4] = 32'h14; offs[5] = 32'h100;
        for (int i = 0; i < n; i++) begin
            mmio_req  = ($urandom_range(3) != 0);
            mmio_we   = ($urandom_range(3) != 0);
            mmio_addr = BASE + offs[$urandom_range(5)];
            wdata     = {$urandom, $urandom};
            wdata_t0  = {$urandom, $urandom};
            rec_ready = ($urandom_range(99) < ready_pct);
            cyc();
        end
        set_idle();
    endtask

    task automatic do_reset();
        rst_ni = 0;
        #1;
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_rec_data", rec_data, 0);
        chk("rst_rec_idx", rec_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_stop_req", stop_req, 0);
        chk("rst_cause", done_cause, 0);
        chk("rst_trap_seen", trap_seen, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_step_cnt", step_cnt, 0);
        set_idle();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        model_reset();
    endtask

    initial begin
        int n;
        total = 0; passed = 0;
        set_idle();
        trap_en = 0; simlen = 0; rec_ready = 1;
        do_reset();

        // Channel-0 writes with the consumer always ready.
        wr(32'h10, 64'hA, 64'h0);
        chk("ch0_first_idx", rec_idx, 1);
        chk("ch0_first_data", rec_data, 64'hA);
        wr(32'h10, 64'hB, 64'hF);
        chk("ch0_second_taint", rec_taint, 64'hF);
        wr(32'h10, 64'hC, 64'h0);
        chk("ch0_third_idx", rec_idx, 3);
        idle(2);

        // Channel 2 then channel 1; a read to a dump slot records nothing.
        wr(32'h20, 64'h22, 64'h1);
        chk("ch2_rec_ch", rec_ch, 2);
        wr(32'h18, 64'h11, 64'h2);
        chk("ch1_rec_idx", rec_idx, 0);
        rd(32'h10);
        chk("read_no_record", rec_valid, 0);
        idle(2);

        rand_phase(300, 50);
        rand_phase(300, 20);

        // Asynchronous reset while records are likely pending.
        do_reset();

        // Overflow: FIFO_DEPTH+2 writes with no consumer.
        rec_ready = 0;
        for (int i = 0; i < DEPTH + 2; i++) wr(32'h10, 64'(i), 64'(i * 3));
        chk("ovf_flag", overflow, 1);
        rec_ready = 1;
        idle(DEPTH);
        chk("ovf_drained", rec_valid, 0);
        wr(32'h10, 64'h77, 64'h0);
        chk("ovf_next_idx", rec_idx, 1 + 18);
        idle(2);

        // Stop with records pending and dumps arriving during the drain.
        do_reset();
        rec_ready = 0;
        wr(32'h10, 64'h1, 64'h0);
        wr(32'h18, 64'h2, 64'h0);
        wr(32'h20, 64'h3, 64'h0);
        n = now;
        wr(32'h0, 64'h0, 64'h0);
        chk("stop_req_n1", stop_req, 1);
        while (now < n + 60) begin
            rand_dump();
            rec_ready = (now > n + 52);
            cyc();
            if (now == n + 50) chk("stop_done_early", done, 0);
            if (now == n + 51) chk("stop_done_n51", done, 1);
        end
        rec_ready = 1;
        idle(5);
        chk("stop_cause", done_cause, 1);

        // Trap read: flag only, then trap with stop enabled.
        do_reset();
        trap_en = 0;
        rd(32'h8);
        chk("trap_flag", trap_seen, 1);
        idle(3);
        chk("trap_still_run", stop_req, 0);
        trap_en = 1;
        n = now;
        rd(32'h8);
        while (now < n + 55) begin
            cyc();
            if (now == n + 50) chk("trap_done_early", done, 0);
            if (now == n + 51) chk("trap_done_n51", done, 1);
        end
        chk("trap_cause", done_cause, 2);
        trap_en = 0;

        // Cycle limit beats a stop in the same cycle.
        simlen = 100;
        do_reset();
        while (now < 99) cyc();
        wr(32'h0, 64'h0, 64'h0);
        chk("simlen_done", done, 1);
        chk("simlen_cause", done_cause, 3);
        chk("simlen_step", step_cnt, 100);
        chk("simlen_no_stop", stop_req, 0);
        idle(10);

        // Unlimited run never finishes without a stop.
        simlen = 0;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            rand_dump();
            rec_ready = 1'($urandom_range(1));
            cyc();
        end
        set_idle();
        chk("unlimited_not_done", done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
